// File: rtl/fp_pkg.sv
// Shared float constants and accumulate-sequencer state encoding.
// Imported by the sequencer and its benches.
package fp_pkg;

    localparam logic [31:0] FP_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
    localparam logic [31:0] FP_QNAN = 32'hFFC0_0000;

    typedef enum logic [2:0] {
        IDLE,
        SEND_A,
        SEND_B,
        WAIT_Z,
        OUT
    } seq_state_t;

endpackage

// File: rtl/fp_accum_sequencer.sv
// Folds a float stream into a running sum through one external stb/ack adder.
// One adder transaction outstanding at a time; result held until taken.
module fp_accum_sequencer
    import fp_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [31:0]      add_a,
    output logic             add_a_stb,
    input  logic             add_a_ack,
    output logic [31:0]      add_b,
    output logic             add_b_stb,
    input  logic             add_b_ack,
    input  logic [31:0]      add_z,
    input  logic             add_z_stb,
    output logic             add_z_ack,
    output logic [31:0]      out_sum,
    output logic [LEN_W-1:0] out_count,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    seq_state_t state, state_n;

    logic [31:0]      acc;
    logic [31:0]      elem;
    logic             last;
    logic [LEN_W-1:0] cnt;

    logic in_fire, a_fire, b_fire, z_fire, out_fire;

    assign in_fire  = (state == IDLE) & in_valid & in_ready;
    assign a_fire   = add_a_stb & add_a_ack;
    assign b_fire   = add_b_stb & add_b_ack;
    assign z_fire   = add_z_ack & add_z_stb;
    assign out_fire = out_valid & out_ready;

    // in_ready is registered so it stays low through reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            acc       <= FP_ZERO;
            elem      <= FP_ZERO;
            last      <= 1'b0;
            cnt       <= '0;
            out_sum   <= FP_ZERO;
            out_count <= '0;
        end else begin
            state    <= state_n;
            in_ready <= (state_n == IDLE);
            if (in_fire) begin
                elem <= in_data;
                last <= in_last;
                cnt  <= cnt + LEN_W'(1);
            end
            if (z_fire) begin
                acc <= add_z;
                if (last) begin
                    out_sum   <= add_z;
                    out_count <= cnt;
                end
            end
            if (out_fire) begin
                acc <= FP_ZERO;
                cnt <= '0;
            end
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (in_fire)  state_n = SEND_A;
            SEND_A:  if (a_fire)   state_n = SEND_B;
            SEND_B:  if (b_fire)   state_n = WAIT_Z;
            WAIT_Z:  if (z_fire)   state_n = last ? OUT : IDLE;
            OUT:     if (out_fire) state_n = IDLE;
            default:               state_n = IDLE;
        endcase
    end

    always_comb begin
        add_a_stb = (state == SEND_A);
        add_b_stb = (state == SEND_B);
        add_z_ack = (state == WAIT_Z);
        out_valid = (state == OUT);
        busy      = (state != IDLE);
    end

    assign add_a = acc;
    assign add_b = elem;

endmodule
